// File: rtl/prog_counter.sv
// -----------------------------------------------------------------------------
// prog_counter
//   Programmable up/down event counter with prescaler, runtime modulus,
//   wrap or saturate boundary handling, synchronous clear and parallel load.
//   Emits a registered one-cycle terminal-count pulse on every boundary step
//   and keeps a sticky overflow flag until software clears it.
//
// Parameters
//   WIDTH       width of count, modulus and load value
//   PRESCALE_W  width of the prescaler compare value
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   enable      counting enable, gates the prescaler
//   clear       synchronous clear of count and prescaler
//   load        synchronous parallel load of min(load_value, modulus)
//   load_value  value applied on load
//   up_down     1 = count up, 0 = count down
//   sat_mode    1 = saturate at boundary, 0 = wrap
//   modulus     top of count range (range is 0..modulus inclusive)
//   prescale    tick every prescale+1 enabled cycles
//   ovf_clear   clears the sticky overflow flag (a same-cycle set wins)
//   count       registered count
//   tc          registered terminal-count pulse
//   overflow    sticky boundary flag
// -----------------------------------------------------------------------------
module prog_counter #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  clear,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_value,
   input  logic                  up_down,
   input  logic                  sat_mode,
   input  logic [WIDTH-1:0]      modulus,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  ovf_clear,
   output logic [WIDTH-1:0]      count,
   output logic                  tc,
   output logic                  overflow
);

   // Resolved operation for this cycle, in priority order.
   typedef enum logic [1:0] {
      OP_IDLE,
      OP_CLEAR,
      OP_LOAD,
      OP_TICK
   } op_e;

   op_e                   op;
   logic                  tick;

   logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [WIDTH-1:0]      count_q,   count_d;
   logic                  tc_q,      tc_d;
   logic                  ovf_q,     ovf_d;

   logic                  at_top;
   logic                  at_bottom;
   logic                  boundary;
   logic [WIDTH-1:0]      load_clamped;
   logic [WIDTH-1:0]      step_val;

   // ---------------------------------------------------------------------------
   // Prescaler tick: equality compare only, so lowering prescale below the
   // running pre_cnt lets the counter run through its full range first.
   // ---------------------------------------------------------------------------
   always_comb begin
      tick = enable && (pre_cnt_q == prescale);
   end

   always_comb begin
      op = OP_IDLE;
      if (clear) begin
         op = OP_CLEAR;
      end else if (load) begin
         op = OP_LOAD;
      end else if (tick) begin
         op = OP_TICK;
      end
   end

   always_comb begin
      pre_cnt_d = pre_cnt_q;
      if (clear || load) begin
         pre_cnt_d = '0;
      end else if (enable) begin
         if (tick) begin
            pre_cnt_d = '0;
         end else begin
            pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Step value. at_top uses >= so a modulus lowered beneath a stale count
   // turns the next up tick into a boundary; the down path only looks at
   // zero and therefore decrements normally from the stale count.
   // ---------------------------------------------------------------------------
   always_comb begin
      at_top    = (count_q >= modulus);
      at_bottom = (count_q == '0);
      boundary  = up_down ? at_top : at_bottom;
      step_val  = count_q;
      if (up_down) begin
         if (at_top) begin
            step_val = sat_mode ? modulus : '0;
         end else begin
            step_val = count_q + WIDTH'(1);
         end
      end else begin
         if (at_bottom) begin
            step_val = sat_mode ? '0 : modulus;
         end else begin
            step_val = count_q - WIDTH'(1);
         end
      end
   end

   always_comb begin
      load_clamped = (load_value > modulus) ? modulus : load_value;
   end

   // ---------------------------------------------------------------------------
   // Next-state: count, tc and overflow.
   // ---------------------------------------------------------------------------
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      ovf_d   = ovf_clear ? 1'b0 : ovf_q;
      unique case (op)
         OP_CLEAR: begin
            count_d = '0;
         end
         OP_LOAD: begin
            count_d = load_clamped;
         end
         OP_TICK: begin
            count_d = step_val;
            if (boundary) begin
               tc_d  = 1'b1;
               ovf_d = 1'b1;
            end
         end
         default: begin
            count_d = count_q;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt_q <= '0;
         count_q   <= '0;
         tc_q      <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
         count_q   <= count_d;
         tc_q      <= tc_d;
         ovf_q     <= ovf_d;
      end
   end

   assign count    = count_q;
   assign tc       = tc_q;
   assign overflow = ovf_q;

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
- Parametrised, programmable successor to the basic free-running counter.
- Counts up or down on prescaled enable ticks, with a runtime-programmable modulus and selectable wrap or saturate mode.
- Supports synchronous clear and parallel load.
- Reports a terminal-count pulse and a sticky overflow flag.
- Serves as the general-purpose timer/event-counter primitive for CPU-side timers and test harness counters.

Parameters:
- WIDTH, 32, bit width of the count, modulus and load value.
- PRESCALE_W, 8, bit width of the prescaler compare value.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  counting enable; gates the prescaler.
- clear  input  1  synchronous clear of count and prescaler.
- load  input  1  synchronous parallel load.
- load_value  input  WIDTH  value applied on load.
- up_down  input  1  1 = count up, 0 = count down.
- sat_mode  input  1  1 = saturate at boundary, 0 = wrap.
- modulus  input  WIDTH  maximum count value; the count range is 0..modulus inclusive.
- prescale  input  PRESCALE_W  tick every prescale+1 enabled cycles.
- ovf_clear  input  1  clears the sticky overflow flag.
- count  output  WIDTH  current count, registered.
- tc  output  1  one-cycle terminal-count pulse, registered.
- overflow  output  1  sticky boundary-crossing flag.

Behaviour:
- Reset (asynchronous, active-high): count=0, prescaler=0, tc=0, overflow=0. Reset asserted mid-operation aborts immediately. The first step after deassertion occurs only once a full prescale period has elapsed.
- Priority, highest first: reset > clear > load > tick step.
- Prescaler:
  - Internal counter pre_cnt, PRESCALE_W bits.
  - When enable=1: if pre_cnt==prescale, a tick is generated and pre_cnt<=0; otherwise pre_cnt<=pre_cnt+1.
  - When enable=0: pre_cnt holds and no tick is generated.
  - prescale=0 gives a tick on every enabled cycle.
  - If prescale is lowered below the current pre_cnt, the tick fires when pre_cnt wraps through its full range. There is no early compare.
- Clear: count<=0, pre_cnt<=0, tc<=0. Overflow is unchanged.
- Load: count<=min(load_value, modulus), pre_cnt<=0, tc<=0. Overflow is unchanged. A load in the same cycle as a tick wins, and the tick is discarded.
- Up step (tick, up_down=1):
  - count<modulus: count<=count+1, tc<=0.
  - count>=modulus: the boundary case applies. Wrap mode gives count<=0; saturate mode gives count<=modulus. In both modes tc<=1 and overflow<=1.
- Down step (tick, up_down=0):
  - count>0: count<=count-1, tc<=0.
  - count==0: the boundary case applies. Wrap mode gives count<=modulus; saturate mode holds at 0. In both modes tc<=1 and overflow<=1.
- Saturated state: every further tick in the same direction re-pulses tc.
- No-tick cycles: tc<=0.
- tc latency: tc rises on the same edge that applies the boundary update and is high for exactly one cycle per boundary tick.
- Modulus cases:
  - modulus=0: count is pinned at 0 and every tick is a boundary, so tc=1 each tick.
  - modulus=all-ones, wrap, up: plain full-range wrap 2^WIDTH-1 -> 0.
  - Modulus changed below the current count: the next up tick is treated as a boundary. The next down tick decrements normally from the stale count.
- Arithmetic: all comparisons are unsigned, WIDTH bits. There is no internal carry beyond WIDTH; boundary detection replaces overflow arithmetic.
- Overflow flag:
  - Set on any boundary step; cleared by ovf_clear.
  - Simultaneous set and ovf_clear: set wins.
- Changing up_down or sat_mode mid-count takes effect on the next tick. No state is flushed.

Test Plan:
1. Reset mid-count: count=5, assert reset asynchronously between edges -> count=0, tc=0, overflow=0 immediately. After release with prescale=0 and enable=1, count=1 after the first edge.
2. Up, wrap, modulus=9, prescale=0, 12 enabled cycles -> count sequence 1..9,0,1,2. tc high only on the edge where count becomes 0. Overflow=1 thereafter until ovf_clear.
3. Down, saturate, load_value=2, prescale=0 -> counts 1,0,0,0 with tc high on the 3rd and 4th ticks. Then load_value=20 with modulus=9 -> count=9 (clamped).
4. Prescale=3, enable=1 continuous, up -> count increments once every 4 cycles. Deassert enable for 5 cycles mid-period -> phase preserved, with no extra or lost tick.
5. Simultaneous events: load with a tick present -> load value applied, no step, tc=0. A boundary tick together with ovf_clear -> overflow=1. Clear together with load -> count=0.
6. WIDTH=8, modulus=8'hFF, up, wrap -> count 8'hFE, 8'hFF, 8'h00 with a tc pulse. Then lower modulus to 8'h10 while count=8'h20 and tick up -> count=0, tc=1.
